demux_stream: RTL and testbench

DEMUX_STREAM -- requirements
Module: demux_stream

---
 rtl/demux_stream_pkg.sv | 15 +
 rtl/demux_chan_fifo.sv | 76 +++++++
 rtl/demux_stream.sv | 75 +++++++
 tb/tb_demux_stream.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_stream_pkg.sv
// Shared definitions for the demux_stream block: channel index type,
// channel count, statistics counter width and the saturating increment.
package demux_stream_pkg;

  localparam int NUM_CH = 4;
  localparam int STAT_W = 8;

  typedef logic [1:0] ch_idx_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// One output channel of demux_stream: a first-word-fall-through FIFO whose
// head word is held in a register, so the output keeps its last value once
// the buffer runs empty and reads zero straight out of reset.
module demux_chan_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic              full,
  output logic              valid,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [CNT_W-1:0]  count;
  logic              wr_en;
  logic              pop;

  assign full       = (count == CNT_W'(DEPTH));
  assign valid      = (count != '0);
  assign wr_en      = push & ~full;
  assign pop        = valid & rd_ready;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

  // Storage array: data only, no reset needed since pointers define content.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // The next head comes from the slot behind the popped one when it is
      // already filled; otherwise an incoming word becomes the head directly
      // (that slot is being written this very cycle).
      if (pop) begin
        if (count > CNT_W'(1)) begin
          head <= mem[rd_ptr_nxt];
        end else if (wr_en) begin
          head <= wr_data;
        end
      end else if (wr_en && (count == '0)) begin
        head <= wr_data;
      end
    end
  end

endmodule

// File: rtl/demux_stream.sv
// demux_stream: steers each input word to one of four buffered output
// channels selected by sel. Each channel is an independent FWFT FIFO.
// Optional per-channel accept counters are built when DEMUX_STREAM_STATS_EN
// is defined (adds stat_clr / stat_cnt ports).
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        din,
  input  ch_idx_t                  sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        y0,
  output logic [DATA_W-1:0]        y1,
  output logic [DATA_W-1:0]        y2,
  output logic [DATA_W-1:0]        y3,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready
`ifdef DEMUX_STREAM_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [NUM_CH*STAT_W-1:0] stat_cnt
`endif
);

  logic [NUM_CH-1:0] full_vec;
  logic [NUM_CH-1:0] push_vec;
  logic [DATA_W-1:0] y_arr [NUM_CH];

  // Readiness depends only on the selected channel's fullness.
  assign in_ready = ~full_vec[sel];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign push_vec[k] = in_valid & (sel == ch_idx_t'(k)) & ~full_vec[k];

    demux_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push_vec[k]),
      .wr_data  (din),
      .rd_ready (out_ready[k]),
      .full     (full_vec[k]),
      .valid    (out_valid[k]),
      .head     (y_arr[k])
    );
  end

  assign y0 = y_arr[0];
  assign y1 = y_arr[1];
  assign y2 = y_arr[2];
  assign y3 = y_arr[3];

`ifdef DEMUX_STREAM_STATS_EN
  // Saturating per-channel accept counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push_vec[k]) begin
          stat_cnt[k*STAT_W +: STAT_W] <= sat_inc(stat_cnt[k*STAT_W +: STAT_W]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Directed testbench for demux_stream (DATA_W=4, DEPTH=2). Statistics
// scenario is included when DEMUX_STREAM_STATS_EN is defined.
module tb_demux_stream;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic [1:0] sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] y0, y1, y2, y3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
`ifdef DEMUX_STREAM_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_cnt;
`endif

  int n_run;
  int n_fail;

  demux_stream #(.DATA_W(4), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_STREAM_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    sel       = 2'd0;
    din       = 4'h0;
    out_ready = 4'b0000;
`ifdef DEMUX_STREAM_STATS_EN
    stat_clr  = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_run++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid); end
    n_run++; if (y0 !== 4'h0) begin n_fail++; $display("FAIL reset_y0: got %h expected 0", y0); end
    n_run++; if (y1 !== 4'h0) begin n_fail++; $display("FAIL reset_y1: got %h expected 0", y1); end
    n_run++; if (y2 !== 4'h0) begin n_fail++; $display("FAIL reset_y2: got %h expected 0", y2); end
    n_run++; if (y3 !== 4'h0) begin n_fail++; $display("FAIL reset_y3: got %h expected 0", y3); end
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; sel = 2'd2; din = 4'hA;
    #1;
    n_run++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL single_no_bypass: got %b expected 0000", out_valid); end
    tick();
    in_valid = 1'b0;
    n_run++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL single_out_valid: got %b expected 0100", out_valid); end
    n_run++; if (y2 !== 4'hA) begin n_fail++; $display("FAIL single_y2: got %h expected a", y2); end
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    n_run++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL single_drained: got %b expected 0000", out_valid); end
    n_run++; if (y2 !== 4'hA) begin n_fail++; $display("FAIL single_y2_hold: got %h expected a", y2); end
  endtask

  task automatic test_full();
    do_reset();
    in_valid = 1'b1; sel = 2'd1; din = 4'h3;
    tick();
    din = 4'h5;
    tick();
    in_valid = 1'b0;
    #1;
    n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_sel1: got %b expected 0", in_ready); end
    sel = 2'd0;
    #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_sel0: got %b expected 1", in_ready); end
    // Channel 1 full must not block channel 2.
    sel = 2'd2; din = 4'hC; in_valid = 1'b1;
    #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_sel2: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_run++; if (out_valid !== 4'b0110) begin n_fail++; $display("FAIL full_valid_mix: got %b expected 0110", out_valid); end
    n_run++; if (y1 !== 4'h3) begin n_fail++; $display("FAIL full_y1_first: got %h expected 3", y1); end
    n_run++; if (y2 !== 4'hC) begin n_fail++; $display("FAIL full_y2: got %h expected c", y2); end
    out_ready = 4'b0010;
    tick();
    n_run++; if (y1 !== 4'h5) begin n_fail++; $display("FAIL full_y1_second: got %h expected 5", y1); end
    n_run++; if (out_valid !== 4'b0110) begin n_fail++; $display("FAIL full_valid_after_pop1: got %b expected 0110", out_valid); end
    tick();
    out_ready = 4'b0000;
    n_run++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL full_valid_after_pop2: got %b expected 0100", out_valid); end
  endtask

  task automatic test_push_pop();
    do_reset();
    in_valid = 1'b1; sel = 2'd3; din = 4'h1;
    tick();
    n_run++; if (y3 !== 4'h1) begin n_fail++; $display("FAIL pp_y3_first: got %h expected 1", y3); end
    din = 4'h7; out_ready = 4'b1000;
    #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_run++; if (out_valid !== 4'b1000) begin n_fail++; $display("FAIL pp_valid: got %b expected 1000", out_valid); end
    n_run++; if (y3 !== 4'h7) begin n_fail++; $display("FAIL pp_y3: got %h expected 7", y3); end
    tick();
    out_ready = 4'b0000;
    n_run++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL pp_occupancy_one: got %b expected 0000", out_valid); end
    n_run++; if (y3 !== 4'h7) begin n_fail++; $display("FAIL pp_y3_hold: got %h expected 7", y3); end
  endtask

  task automatic test_full_pop();
    do_reset();
    in_valid = 1'b1; sel = 2'd0; din = 4'h1;
    tick();
    din = 4'h2;
    tick();
    din = 4'h9; out_ready = 4'b0001;
    #1;
    n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fp_ready: got %b expected 0", in_ready); end
    n_run++; if (y0 !== 4'h1) begin n_fail++; $display("FAIL fp_y0_head: got %h expected 1", y0); end
    tick();
    in_valid = 1'b0;
    n_run++; if (y0 !== 4'h2) begin n_fail++; $display("FAIL fp_y0_after_pop: got %h expected 2", y0); end
    n_run++; if (out_valid !== 4'b0001) begin n_fail++; $display("FAIL fp_valid: got %b expected 0001", out_valid); end
    tick();
    out_ready = 4'b0000;
    n_run++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL fp_word_dropped: got %b expected 0000", out_valid); end
    n_run++; if (y0 !== 4'h2) begin n_fail++; $display("FAIL fp_y0_hold: got %h expected 2", y0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1;
    sel = 2'd0; din = 4'h4; tick();
    sel = 2'd1; din = 4'h5; tick();
    sel = 2'd2; din = 4'h6; tick();
    n_run++; if (out_valid !== 4'b0111) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 0111", out_valid); end
    rst = 1'b1; sel = 2'd3; din = 4'hF; out_ready = 4'b1111;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
    #1;
    n_run++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_valid: got %b expected 0000", out_valid); end
    n_run++; if ({y0, y1, y2, y3} !== 16'h0000) begin n_fail++; $display("FAIL mid_y: got %h expected 0000", {y0, y1, y2, y3}); end
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
  endtask

`ifdef DEMUX_STREAM_STATS_EN
  task automatic test_stats();
    do_reset();
    in_valid = 1'b1; sel = 2'd0; din = 4'h8; out_ready = 4'b0001;
    repeat (300) tick();
    n_run++; if (stat_cnt[7:0] !== 8'd255) begin n_fail++; $display("FAIL stats_sat: got %0d expected 255", stat_cnt[7:0]); end
    n_run++; if (stat_cnt[31:8] !== 24'd0) begin n_fail++; $display("FAIL stats_other: got %h expected 000000", stat_cnt[31:8]); end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    n_run++; if (stat_cnt[7:0] !== 8'd0) begin n_fail++; $display("FAIL stats_clr: got %0d expected 0", stat_cnt[7:0]); end
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    n_run++; if (stat_cnt[7:0] !== 8'd1) begin n_fail++; $display("FAIL stats_after_clr: got %0d expected 1", stat_cnt[7:0]); end
  endtask
`endif

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_full();
    test_push_pop();
    test_full_pop();
    test_reset_mid();
`ifdef DEMUX_STREAM_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
